// File: rtl/crank_cam_gen.sv
// Trigger-wheel generator: TEETH-MISSING crank tooth train plus half-speed cam,
// with per-revolution period reload from a shadow register or signed ramp.
module crank_cam_gen #(
  parameter int TEETH      = 60,
  parameter int MISSING    = 2,
  parameter int PER_W      = 16,
  parameter int PER_RST    = 64,
  parameter int PER_MIN    = 4,
  parameter int CAM_TOGGLE = 30,
  parameter int CAM_FALL   = 54,
  parameter int CAM_RISE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             per_wr,
  input  logic [PER_W-1:0] per_in,
  input  logic [PER_W-1:0] ramp,
  output logic             vr,
  output logic             cam,
  output logic             cam_phase,
  output logic [7:0]       tooth_idx,
  output logic             rev_pulse,
  output logic [PER_W-1:0] per_act
);

  localparam int CNT_W = PER_W + 2;
  localparam int SUM_W = PER_W + 2;

  localparam logic [7:0]             LAST_IDX   = 8'(TEETH - MISSING - 1);
  localparam logic [7:0]             IDX_TOGGLE = 8'(CAM_TOGGLE);
  localparam logic [7:0]             IDX_FALL   = 8'(CAM_FALL);
  localparam logic [7:0]             IDX_RISE   = 8'(CAM_RISE);
  localparam logic [PER_W-1:0]       PER_MIN_V  = PER_W'(PER_MIN);
  localparam logic [PER_W-1:0]       PER_RST_V  = PER_W'(PER_RST);
  localparam logic [CNT_W-1:0]       GAP_MUL    = CNT_W'(MISSING + 1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic signed [SUM_W-1:0] SUM_MIN   = SUM_W'(PER_MIN);
  localparam logic signed [SUM_W-1:0] SUM_MAX   = {2'b00, {PER_W{1'b1}}};

  logic [CNT_W-1:0]        tick, tick_nxt, len_cur, len_nxt;
  logic [PER_W-1:0]        shadow, per_nxt, per_ramped, per_in_sat;
  logic [7:0]              idx_nxt;
  logic                    pending, tooth_end, wrap, vr_nxt;
  logic signed [SUM_W-1:0] sum;

  // The last present tooth also spans the missing teeth that follow it.
  function automatic logic [CNT_W-1:0] tooth_len(input logic [7:0] idx,
                                                 input logic [PER_W-1:0] per);
    logic [CNT_W-1:0] base;
    base = CNT_W'(per);
    return (idx == LAST_IDX) ? base * GAP_MUL : base;
  endfunction

  // NOTE: every variable below gets a value on every path through this block,
  // so no latch can be inferred.
  always_comb begin
    sum = $signed({2'b00, per_act}) + $signed({{2{ramp[PER_W-1]}}, ramp});
    if (sum < SUM_MIN)      per_ramped = PER_MIN_V;
    else if (sum > SUM_MAX) per_ramped = '1;
    else                    per_ramped = sum[PER_W-1:0];

    per_in_sat = (per_in < PER_MIN_V) ? PER_MIN_V : per_in;

    len_cur   = tooth_len(tooth_idx, per_act);
    tooth_end = (tick == len_cur - CNT_ONE);
    wrap      = tooth_end && (tooth_idx == LAST_IDX);
    tick_nxt  = tooth_end ? '0 : tick + CNT_ONE;

    if (wrap)           idx_nxt = '0;
    else if (tooth_end) idx_nxt = tooth_idx + 8'd1;
    else                idx_nxt = tooth_idx;

    // A pending shadow write wins over the ramp for this revolution.
    if (!wrap)        per_nxt = per_act;
    else if (pending) per_nxt = shadow;
    else              per_nxt = per_ramped;

    // vr is computed from the post-edge tick so it lines up with the tooth.
    len_nxt = tooth_len(idx_nxt, per_nxt);
    vr_nxt  = (tick_nxt >= (len_nxt >> 1));
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= '0;
      tooth_idx <= '0;
      vr        <= 1'b0;
      cam       <= 1'b1;
      cam_phase <= 1'b0;
      rev_pulse <= 1'b0;
      per_act   <= PER_RST_V;
      shadow    <= PER_RST_V;
      pending   <= 1'b0;
    end else begin
      rev_pulse <= en && wrap;

      // A write in the wrap cycle survives the clear and applies next wrap.
      if (per_wr) begin
        shadow  <= per_in_sat;
        pending <= 1'b1;
      end else if (en && wrap) begin
        pending <= 1'b0;
      end

      if (en) begin
        tick      <= tick_nxt;
        tooth_idx <= idx_nxt;
        per_act   <= per_nxt;
        vr        <= vr_nxt;
        if (tooth_end) begin
          if (idx_nxt == IDX_TOGGLE)             cam_phase <= ~cam_phase;
          if (cam_phase && idx_nxt == IDX_FALL)  cam       <= 1'b0;
          if (cam_phase && idx_nxt == IDX_RISE)  cam       <= 1'b1;
        end
      end
    end
  end

endmodule
